// File: rtl/simon_sequence_player_if.sv
// Control and display signals of the Simon sequence player.
// The controller side drives the master modport; the player uses the slave modport.
interface simon_sequence_player_if;
  logic        Start;
  logic        Abort;
  logic [29:0] Seq;
  logic [3:0]  Len;
  logic [2:0]  Color;
  logic [3:0]  Index;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Abort, Seq, Len,
    input  Color, Index, Busy, Done
  );

  modport slave (
    input  Start, Abort, Seq, Len,
    output Color, Index, Busy, Done
  );
endinterface

// File: rtl/simon_sequence_player.sv
// Plays a latched list of Simon colors: each entry is shown for ON_TICKS cycles,
// then the display is blanked for OFF_TICKS cycles, followed by a one-cycle Done pulse.
module simon_sequence_player #(
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2,
  parameter int MAX_LEN   = 10
) (
  input logic                    Clk,
  input logic                    Reset,
  simon_sequence_player_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Seq only carries ten 3-bit entries, so the usable length can never exceed ten.
  localparam int          LEN_CAP    = (MAX_LEN > 10) ? 10 : MAX_LEN;
  localparam logic [3:0]  LEN_CAP_L  = 4'(LEN_CAP);
  localparam logic [15:0] ON_RELOAD  = 16'(ON_TICKS - 1);
  localparam logic [15:0] OFF_RELOAD = 16'(OFF_TICKS - 1);

  state_t      state;
  logic [15:0] dwell_cnt;
  logic [29:0] seq_q;
  logic [3:0]  len_q;
  logic [3:0]  index_q;
  logic [2:0]  color_q;
  logic        busy_q;
  logic        done_q;

  // Codes outside 1..4 are shown as blank.
  function automatic logic [2:0] entry_color(input logic [29:0] seq, input logic [3:0] k);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 0; i < 10; i++) begin
      if (k == 4'(i)) code = seq[3*i +: 3];
    end
    return (code >= 3'd1 && code <= 3'd4) ? code : 3'd0;
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > LEN_CAP_L) ? LEN_CAP_L : len;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      seq_q     <= '0;
      len_q     <= '0;
      index_q   <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.Abort) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          color_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          // Outputs are registered, so the first color is loaded on the Start edge itself.
          if (bus.Start && bus.Len != 4'd0) begin
            seq_q     <= bus.Seq;
            len_q     <= clamp_len(bus.Len);
            index_q   <= '0;
            dwell_cnt <= ON_RELOAD;
            color_q   <= entry_color(bus.Seq, 4'd0);
            busy_q    <= 1'b1;
            state     <= SHOW;
          end
        end

        SHOW: begin
          if (dwell_cnt == 16'd0) begin
            dwell_cnt <= OFF_RELOAD;
            color_q   <= '0;
            state     <= GAP;
          end else begin
            dwell_cnt <= dwell_cnt - 16'd1;
          end
        end

        GAP: begin
          if (dwell_cnt == 16'd0) begin
            if ((index_q + 4'd1) < len_q) begin
              index_q   <= index_q + 4'd1;
              dwell_cnt <= ON_RELOAD;
              color_q   <= entry_color(seq_q, index_q + 4'd1);
              state     <= SHOW;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            dwell_cnt <= dwell_cnt - 16'd1;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          color_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.Color = color_q;
  assign bus.Index = index_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

  // Done is only ever raised inside a busy playback, and the display is dark when idle.
  a_done_busy: assert property (@(posedge Clk) disable iff (Reset) done_q |-> busy_q);
  a_idle_dark: assert property (@(posedge Clk) disable iff (Reset) !busy_q |-> (color_q == 3'd0));

endmodule

// File: tb/tb_simon_sequence_player.sv
// Directed bench for simon_sequence_player with ON_TICKS=4, OFF_TICKS=2, MAX_LEN=10.
module tb_simon_sequence_player;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  simon_sequence_player_if bus_if ();

  simon_sequence_player #(
    .ON_TICKS (4),
    .OFF_TICKS(2),
    .MAX_LEN  (10)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        start;
    logic        abort;
    logic [3:0]  len;
    logic [29:0] seq;
    logic [2:0]  color;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [20];

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] c, input logic [3:0] ix,
                       input logic b, input logic d);
    checks++;
    if (bus_if.Color !== c || bus_if.Index !== ix || bus_if.Busy !== b || bus_if.Done !== d) begin
      errors++;
      $display("FAIL %s: got color=%0d index=%0d busy=%0b done=%0b, want color=%0d index=%0d busy=%0b done=%0b",
               name, bus_if.Color, bus_if.Index, bus_if.Busy, bus_if.Done, c, ix, b, d);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Applies table rows [from..to]; perturb re-pulses Start mid-play and scrambles Seq/Len.
  task automatic run_table(input int from, input int to, input bit perturb, input string tag);
    for (int i = from; i <= to; i++) begin
      bus_if.Start = tbl[i].start;
      bus_if.Abort = tbl[i].abort;
      bus_if.Len   = tbl[i].len;
      bus_if.Seq   = tbl[i].seq;
      if (perturb && i > 0) begin
        bus_if.Start = (i == 4) || (i == 11) || (i == 18);
        bus_if.Seq   = 30'h2492_4924;
        bus_if.Len   = 4'd9;
      end
      cyc();
      check($sformatf("%s[%0d]", tag, i), tbl[i].color, tbl[i].idx, tbl[i].busy, tbl[i].done);
    end
    bus_if.Start = 1'b0;
    bus_if.Abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n_busy;
    int windows;
    int max_idx;
    int done_at;
    int bad_color;
    logic [2:0] prev_c;

    errors = 0;
    checks = 0;

    //          start abort len    seq          color idx   busy  done
    tbl[0]  = '{1'b1, 1'b0, 4'd3, 30'h0D1, 3'd1, 4'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd1, 4'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd1, 4'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd1, 4'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd2, 4'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd2, 4'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd2, 4'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd2, 4'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd3, 4'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd3, 4'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd3, 4'd2, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd3, 4'd2, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd2, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd2, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd2, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 4'd3, 30'h0D1, 3'd0, 4'd2, 1'b0, 1'b0};

    Reset        = 1'b1;
    bus_if.Start = 1'b0;
    bus_if.Abort = 1'b0;
    bus_if.Seq   = '0;
    bus_if.Len   = '0;
    cyc();
    cyc();
    check("reset_state", 3'd0, 4'd0, 1'b0, 1'b0);
    Reset = 1'b0;

    // Len=0 Start is ignored.
    bus_if.Start = 1'b1;
    bus_if.Len   = 4'd0;
    bus_if.Seq   = 30'h0D1;
    cyc();
    check("len0_start", 3'd0, 4'd0, 1'b0, 1'b0);
    bus_if.Start = 1'b0;
    cyc();
    check("len0_after", 3'd0, 4'd0, 1'b0, 1'b0);

    // Abort wins over Start in IDLE.
    bus_if.Start = 1'b1;
    bus_if.Abort = 1'b1;
    bus_if.Len   = 4'd3;
    cyc();
    check("abort_over_start", 3'd0, 4'd0, 1'b0, 1'b0);
    bus_if.Start = 1'b0;
    bus_if.Abort = 1'b0;

    run_table(0, 19, 1'b0, "basic3");
    run_table(0, 19, 1'b1, "restart_ignored");

    // Abort during the second SHOW window, then replay from entry 0.
    run_table(0, 6, 1'b0, "abort_pre");
    bus_if.Abort = 1'b1;
    cyc();
    check("abort_next", 3'd0, 4'd1, 1'b0, 1'b0);
    bus_if.Abort = 1'b0;
    cyc();
    check("abort_idle", 3'd0, 4'd1, 1'b0, 1'b0);
    run_table(0, 19, 1'b0, "abort_replay");

    // Len above MAX_LEN is clamped to ten GREEN entries.
    n_busy    = 0;
    windows   = 0;
    max_idx   = 0;
    done_at   = -1;
    bad_color = 0;
    prev_c    = 3'd0;
    bus_if.Start = 1'b1;
    bus_if.Len   = 4'd15;
    bus_if.Seq   = 30'h2492_4924;
    for (int n = 0; n < 100; n++) begin
      cyc();
      bus_if.Start = 1'b0;
      if (bus_if.Busy === 1'b1) n_busy++;
      if (bus_if.Color == 3'd4 && prev_c != 3'd4) windows++;
      if (bus_if.Color != 3'd4 && bus_if.Color != 3'd0) bad_color++;
      if (int'(bus_if.Index) > max_idx) max_idx = int'(bus_if.Index);
      prev_c = bus_if.Color;
      if (bus_if.Done === 1'b1) begin
        done_at = n;
        break;
      end
    end
    check_int("len15_done_cycle", done_at, 60);
    check_int("len15_busy_cycles", n_busy, 61);
    check_int("len15_windows", windows, 10);
    check_int("len15_max_index", max_idx, 9);
    check_int("len15_bad_colors", bad_color, 0);
    cyc();
    check("len15_idle", 3'd0, 4'd9, 1'b0, 1'b0);

    // Reset during the GAP of entry 1, then an invalid code 7 is blanked.
    run_table(0, 10, 1'b0, "reset_pre");
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check("reset_mid_gap", 3'd0, 4'd0, 1'b0, 1'b0);
    cyc();
    check("reset_no_done", 3'd0, 4'd0, 1'b0, 1'b0);
    bus_if.Start = 1'b1;
    bus_if.Len   = 4'd2;
    bus_if.Seq   = 30'h017;
    cyc();
    bus_if.Start = 1'b0;
    check("code7_show0", 3'd0, 4'd0, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      cyc();
      check($sformatf("code7_show%0d", k), 3'd0, 4'd0, 1'b1, 1'b0);
    end
    cyc();
    cyc();
    check("code7_gap", 3'd0, 4'd0, 1'b1, 1'b0);
    cyc();
    check("code7_entry1", 3'd2, 4'd1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc();
    check("code7_done", 3'd0, 4'd1, 1'b1, 1'b1);
    cyc();
    check("code7_idle", 3'd0, 4'd1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
